// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU logic engines: opcodes and serial FSM states.
package alu_logic_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_bit1.sv
// One-bit logic function f(op, a, b); shared bit-level reference for the ALU.
module logic_bit1
  import alu_logic_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y
);

  // Select the logic function for the current opcode
  always_comb begin
    o_y = 1'b0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NAND: o_y = ~(i_a & i_b);
      default: o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_logic_serial8.sv
// Bit-serial AND/OR/XOR/NAND engine: accepts parallel operands, evaluates one
// bit per clock LSB first, and returns the parallel result with a zero flag.
module alu_logic_serial8
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             w_bit;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_r_next;

  logic_bit1 u_bit (
    .i_op (r_op),
    .i_a  (r_sa[0]),
    .i_b  (r_sb[0]),
    .o_y  (w_bit)
  );

  assign w_r_next = {w_bit, r_r[WIDTH-1:1]};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // Next-state logic and handshake flags
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Operand shift registers, bit counter and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_r   <= '0;
      r_op  <= OP_AND;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= A;
      r_sb  <= B;
      r_op  <= op;
      r_r   <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_r  <= w_r_next;
      r_sa <= r_sa >> 1;
      r_sb <= r_sb >> 1;
      // Hold the counter on the last bit so it never wraps past WIDTH-1
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result and zero flag, loaded only when the last bit completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      zero <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      out  <= w_r_next;
      zero <= ~|w_r_next;
    end
  end

endmodule

// File: doc/alu_logic_serial8.md
# alu_logic_serial8

Bit-serial logic engine for the 8-bit ALU. It accepts two parallel operands and an opcode through a valid/ready handshake. It then evaluates AND/OR/XOR/NAND one bit per clock, LSB first, and presents the parallel result with a zero flag through a second valid/ready handshake. It is the area-lean sequential counterpart to the combinational per-bit logic units. It sits between the ALU operand registers and the result writeback stage, and its results must match the combinational units bit for bit.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  engine can accept operands.
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result.
- zero  out  1  result equals 0.
- busy  out  1  high in RUN.

## Operation
- Single clock domain. Reset is asynchronous and active-low.
- States:
  - IDLE: in_ready=1. On in_valid=1, capture A, B and op into shift registers sa, sb and op_r, clear cnt and the result register r, then go to RUN.
  - RUN: every edge, compute bit = f(op_r, sa[0], sb[0]) and do:
    - r ← {bit, r[WIDTH-1:1]};
    - sa ← sa>>1;
    - sb ← sb>>1;
    - cnt ← cnt+1.
    - On the edge where cnt==WIDTH-1, load out ← final r, set zero ← (final r==0), and go to DONE.
  - DONE: out_valid=1. out and zero are held stable. On out_ready=1, go to IDLE.
- Combinational flags:
  - in_ready = (state==IDLE).
  - busy = (state==RUN).
  - out_valid = (state==DONE).
- A, B and op are sampled only on the accept edge. Later changes to them have no effect.
- in_valid is ignored outside IDLE. No error or overflow indication exists.
- Arithmetic and width rules:
  - Bit i of out equals f(op, A[i], B[i]) for every i.
  - cnt is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1 during an operation.
- out and zero keep their last value after the DONE→IDLE transition, until the next DONE load.

## Timing
- Reset asserted, at any time including mid-RUN:
  - State goes to IDLE immediately and the operation in flight is aborted with no partial result.
  - out=0, zero=0, out_valid=0, busy=0, in_ready=1.
  - sa, sb, r and cnt are cleared.
- Accept edge T0 = rising edge with state IDLE and in_valid=1.
- Latency:
  - State is RUN during cycles T0..T0+WIDTH-1.
  - out_valid rises after edge T0+WIDTH (8 clocks after accept for WIDTH=8).
- Handshake:
  - Transfer happens on an edge with out_valid=1 and out_ready=1. State is IDLE after that edge.
  - If out_ready is already high when DONE is entered, out_valid lasts exactly one cycle.
- Back-to-back accept is impossible in DONE. Minimum operation period is WIDTH+2 cycles.
- out_ready held low stalls the engine in DONE indefinitely with outputs stable.

## Structure
- Shared package alu_logic_pkg holds:
  - opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11;
  - the state encoding IDLE/RUN/DONE.
- The combinational units may reuse these opcodes.
- Sub-module logic_bit1 computes the 1-bit f(op, a, b). It is instantiated once in the datapath and is reusable by the bench as a bit-level reference.
- The top level contains the FSM, the counter, the shift registers and the output registers.

## Test plan
- After reset release: in_ready=1, out_valid=0, out=0x00, zero=0. Then AND with A=0xF0, B=0x3C → out_valid 8 clocks after accept, out=0x30, zero=0.
- OR with A=0x0F, B=0xA0 and out_ready tied high → out=0xAF, out_valid high for exactly 1 cycle, in_ready=1 the following cycle.
- XOR with A=0xFF, B=0xFF → out=0x00, zero=1. Then NAND with A=0xAA, B=0x55 → out=0xFF, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling A/B/op and pulsing in_valid → out, zero and out_valid stay stable, in_ready=0, nothing new is accepted.
- Reset mid-RUN: assert rst_n=0 after 4 RUN cycles → all outputs return to reset values immediately. After release, AND with A=0x81, B=0xFF → out=0x81.
- Random sweep of 1000 operand/opcode triples with random out_ready gaps → every out equals the bitwise f(op, A, B) computed by logic_bit1, and busy is high for exactly WIDTH cycles per operation.
